sd4_mac_sequencer: RTL and testbench
====================================

// Module: sd4_mac_sequencer
// PURPOSE
//  Job sequencer in front of the SD4 MAC stage1/stage2 pipeline. Accepts 3x3 image windows (9 x 8b) over valid/ready.
//  For each window, replays it against cfg_num_k+1 kernels (9 x 4b weights + 5b exp bias) read from a sync weight buffer.
//  Issues one MAC operand set per cycle. Carries kernel index / last flags alongside the non-stallable MAC pipeline.
//  Signals job completion once the pipeline has drained.
// PARAMETERS
//  KADDR_W   4   kernel-index width; max kernels per job = 2**KADDR_W
//  WIN_W     16  window-count width
//  PIPE_LAT  4   cycles from mac_valid_in to result at MAC output (stage count of downstream pipeline)
// PORTS
//  clk           in   1        clock
//  rst           in   1        async active-low reset
//  start         in   1        job start pulse; sampled only in IDLE
//  cfg_num_k     in   KADDR_W  kernels per window minus 1; latched at start
//  cfg_num_win   in   WIN_W    windows per job minus 1; latched at start
//  busy          out  1        high from start acceptance until done
//  done          out  1        1-cycle pulse, job fully drained
//  img_valid     in   1        window valid
//  img_ready     out  1        window accept
//  img_data      in   72       9 x 8b window, element 0 in [71:64]
//  wgt_rd_en     out  1        weight buffer read strobe
//  wgt_addr      out  KADDR_W  kernel index to read
//  wgt_data      in   36       9 x 4b weights, valid 1 cycle after wgt_rd_en
//  bias_data     in   5        exp bias, same timing as wgt_data
//  image_out     out  72       to stage1 image_in
//  weight_out    out  36       to stage1 weight_in
//  exp_bias_out  out  5        to stage1 exp_bias_in
//  mac_valid_in  out  1        operand set on *_out is live this cycle
//  res_valid     out  1        mac_valid_in delayed PIPE_LAT cycles
//  res_kidx      out  KADDR_W  kernel index of result
//  res_last_win  out  1        result is last kernel of its window
//  res_last_job  out  1        result is last result of the job
// BEHAVIOUR
//  Reset: state IDLE; every output 0; window/kernel counters, window register, tag pipe cleared.
//  Reset mid-job: in-flight tags discarded, no done pulse.
//  FSM IDLE -> WAIT_IMG -> ISSUE -> (WAIT_IMG | DRAIN) -> DONE -> IDLE.
//  IDLE: busy=0, img_ready=0. On start: latch cfg, win=0, goto WAIT_IMG. A start seen outside IDLE is ignored.
//  WAIT_IMG: img_ready=1. On img_valid&img_ready:
//   - capture img_data into win_reg
//   - wgt_rd_en=1, wgt_addr=0, k=0
//   - goto ISSUE
//   img_data is never taken without ready.
//  ISSUE: each cycle drive image_out=win_reg, weight_out=wgt_data, exp_bias_out=bias_data, mac_valid_in=1.
//   - if k<num_k: wgt_rd_en=1, wgt_addr=k+1, k++
//   - if k==num_k: the window ends. If win==num_win goto DRAIN, else win++ and goto WAIT_IMG.
//  Throughput: num_k+1 MAC cycles per window, plus 1 bubble per window (no prefetch).
//  When mac_valid_in=0: image_out, weight_out, exp_bias_out = 0 (stage1 sees zero operands).
//  Tag pipe: PIPE_LAT-deep shift of {mac_valid_in, k, k==num_k, k==num_k && win==num_win}.
//   Outputs res_* from the last tap. No backpressure; downstream must accept every res_valid.
//  DRAIN: waits until the tag pipe holds no valid (inclusive of the res_last_job cycle), then goes to DONE.
//  DONE: done=1 for one cycle, busy=0 next cycle, goto IDLE. A start arriving in DONE is ignored.
//  busy=1 in WAIT_IMG, ISSUE, DRAIN, DONE.
//  Boundaries:
//   - num_k=0: one MAC per window, res_last_win on every result.
//   - num_win=0: single window.
//   - Counters never wrap: k max 2**KADDR_W-1, win max 2**WIN_W-1.
// CONFIGURATION
//  SD4_SEQ_PREFETCH_EN defined:
//   - img_ready is also asserted in the final ISSUE cycle of a non-last window.
//   - If accepted, capture the new window in the cycle after, issue wgt_addr=0 in the same cycle, and stay in ISSUE.
//   - Gives back-to-back windows with zero bubble. If not accepted, fall to WAIT_IMG as normal.
//  Undefined: img_ready only in WAIT_IMG; exactly one bubble cycle per window.
// TESTING
//  T1 reset mid-ISSUE (k=2): all outputs 0 within reset; after release, no res_valid/done until next start.
//  T2 num_k=2, num_win=0, img always valid:
//   - mac_valid_in 3 cycles, wgt_addr 0,1,2
//   - res_kidx 0,1,2, with res_last_win/res_last_job on kidx 2
//   - done 1 cycle after the last res_valid
//  T3 num_k=0, num_win=3, img_valid toggling 1/0:
//   - 4 results, each res_last_win=1, only the 4th with res_last_job=1
//   - no operand captured while img_valid=0
//  T4 start pulsed during busy, and again in the DONE cycle: ignored; cfg change mid-job has no effect on counts.
//  T5 num_k=15, num_win=1, KADDR_W=4:
//   - 32 MACs, wgt_addr wraps 15->0 only at the window boundary
//   - 33 busy issue cycles without prefetch, 32 with SD4_SEQ_PREFETCH_EN
//  T6 operands 0 while idle, and zero-weight kernels: image_out=0 when mac_valid_in=0; res_* unaffected by data values.

Source files
------------

// File: rtl/sd4_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sd4_mac_sequencer_if
// Description : Bundles the image stream, the weight-buffer read port, the
//               MAC operand bus and the result-tag bus of the SD4 MAC
//               sequencer. The slave modport is the sequencer's view and the
//               master modport is the surrounding datapath's view.
// Revision    : 1.0  initial release
// ============================================================================
interface sd4_mac_sequencer_if #(
    parameter int KADDR_W = 4
);
    // image window stream
    logic               img_valid;
    logic               img_ready;
    logic [71:0]        img_data;
    // synchronous weight buffer read port
    logic               wgt_rd_en;
    logic [KADDR_W-1:0] wgt_addr;
    logic [35:0]        wgt_data;
    logic [4:0]         bias_data;
    // operands towards MAC stage1
    logic [71:0]        image_out;
    logic [35:0]        weight_out;
    logic [4:0]         exp_bias_out;
    logic               mac_valid_in;
    // result tags aligned with the MAC output
    logic               res_valid;
    logic [KADDR_W-1:0] res_kidx;
    logic               res_last_win;
    logic               res_last_job;

    modport master (
        output img_valid, img_data, wgt_data, bias_data,
        input  img_ready, wgt_rd_en, wgt_addr,
        input  image_out, weight_out, exp_bias_out, mac_valid_in,
        input  res_valid, res_kidx, res_last_win, res_last_job
    );

    modport slave (
        input  img_valid, img_data, wgt_data, bias_data,
        output img_ready, wgt_rd_en, wgt_addr,
        output image_out, weight_out, exp_bias_out, mac_valid_in,
        output res_valid, res_kidx, res_last_win, res_last_job
    );
endinterface
`default_nettype wire

// File: rtl/sd4_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sd4_mac_sequencer
// Description : Job sequencer in front of the SD4 MAC stage1/stage2
//               pipeline. Each accepted 3x3 window is replayed against
//               num_k+1 kernels fetched from a synchronous weight buffer,
//               one operand set per cycle. A tag pipe carries kernel index
//               and last flags alongside the non-stallable MAC pipeline, and
//               done pulses once the pipe has drained.
//               Optional feature macro SD4_SEQ_PREFETCH_EN: accepts the next
//               window during the final issue cycle of a non-last window so
//               windows run back to back without a bubble.
// Revision    : 1.0  initial release
// ============================================================================
module sd4_mac_sequencer #(
    parameter int KADDR_W  = 4,
    parameter int WIN_W    = 16,
    parameter int PIPE_LAT = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [KADDR_W-1:0] cfg_num_k,
    input  wire logic [WIN_W-1:0]   cfg_num_win,
    output logic                    busy,
    output logic                    done,
    sd4_mac_sequencer_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_IMG = 3'd1,
        S_ISSUE    = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    logic [KADDR_W-1:0] r_num_k;
    logic [WIN_W-1:0]   r_num_win;
    logic [KADDR_W-1:0] r_k;
    logic [WIN_W-1:0]   r_win;
    logic [71:0]        r_win_reg;
    logic               r_busy;
    logic               r_done;
    logic               r_img_ready;
    logic               r_mac_valid;

    // tag pipe, one entry per downstream MAC stage
    logic               r_tag_v  [PIPE_LAT];
    logic [KADDR_W-1:0] r_tag_k  [PIPE_LAT];
    logic               r_tag_lw [PIPE_LAT];
    logic               r_tag_lj [PIPE_LAT];

    logic w_k_last;
    logic w_win_last;
    logic w_pf_ready;
    logic w_pf_take;
    logic w_drain_ok;

    assign w_k_last   = (r_k == r_num_k);
    assign w_win_last = (r_win == r_num_win);

`ifdef SD4_SEQ_PREFETCH_EN
    // the last operand of a non-last window is on the bus: the next window
    // may be taken now and its kernel 0 fetched for the following cycle
    assign w_pf_ready = (r_state == S_ISSUE) && w_k_last && !w_win_last;
`else
    assign w_pf_ready = 1'b0;
`endif
    assign w_pf_take  = w_pf_ready && bus.img_valid;

    assign bus.img_ready = r_img_ready || w_pf_ready;

    // Read kernel 0 on window acceptance, then kernel k+1 while issuing k,
    // so the buffer's one-cycle latency lines data up with each issue cycle.
    assign bus.wgt_rd_en = (r_img_ready && bus.img_valid) || w_pf_take ||
                           ((r_state == S_ISSUE) && !w_k_last);
    assign bus.wgt_addr  = ((r_state == S_ISSUE) && !w_k_last) ? r_k + 1'b1 : '0;

    // stage1 sees zero operands whenever no operand set is live
    assign bus.image_out    = r_mac_valid ? r_win_reg     : '0;
    assign bus.weight_out   = r_mac_valid ? bus.wgt_data  : '0;
    assign bus.exp_bias_out = r_mac_valid ? bus.bias_data : '0;
    assign bus.mac_valid_in = r_mac_valid;

    assign busy = r_busy;
    assign done = r_done;

    // Job control FSM: window/kernel counters and registered handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_num_k     <= '0;
            r_num_win   <= '0;
            r_k         <= '0;
            r_win       <= '0;
            r_win_reg   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_img_ready <= 1'b0;
            r_mac_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_k     <= cfg_num_k;
                        r_num_win   <= cfg_num_win;
                        r_win       <= '0;
                        r_busy      <= 1'b1;
                        r_img_ready <= 1'b1;
                        r_state     <= S_WAIT_IMG;
                    end
                end
                S_WAIT_IMG: begin
                    if (bus.img_valid) begin
                        r_win_reg   <= bus.img_data;
                        r_k         <= '0;
                        r_img_ready <= 1'b0;
                        r_mac_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!w_k_last) begin
                        r_k <= r_k + 1'b1;
                    end else if (w_win_last) begin
                        r_mac_valid <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_win <= r_win + 1'b1;
                        if (w_pf_take) begin
                            r_win_reg <= bus.img_data;
                            r_k       <= '0;
                        end else begin
                            r_mac_valid <= 1'b0;
                            r_img_ready <= 1'b1;
                            r_state     <= S_WAIT_IMG;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_ok) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Drain completes once only the output tap may still hold a valid tag,
    // so done follows the final result by exactly one cycle.
    always_comb begin
        w_drain_ok = 1'b1;
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            if (r_tag_v[i]) begin
                w_drain_ok = 1'b0;
            end
        end
    end

    // Tag shift register mirroring the MAC pipeline depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_tag_v[i]  <= 1'b0;
                r_tag_k[i]  <= '0;
                r_tag_lw[i] <= 1'b0;
                r_tag_lj[i] <= 1'b0;
            end
        end else begin
            r_tag_v[0]  <= r_mac_valid;
            r_tag_k[0]  <= r_mac_valid ? r_k : '0;
            r_tag_lw[0] <= r_mac_valid && w_k_last;
            r_tag_lj[0] <= r_mac_valid && w_k_last && w_win_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_k[i]  <= r_tag_k[i-1];
                r_tag_lw[i] <= r_tag_lw[i-1];
                r_tag_lj[i] <= r_tag_lj[i-1];
            end
        end
    end

    assign bus.res_valid    = r_tag_v[PIPE_LAT-1];
    assign bus.res_kidx     = r_tag_k[PIPE_LAT-1];
    assign bus.res_last_win = r_tag_lw[PIPE_LAT-1];
    assign bus.res_last_job = r_tag_lj[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_sd4_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd4_mac_sequencer
// Description : Self-checking bench for sd4_mac_sequencer. Each job's
//               expected operand stream, weight read addresses and result
//               tags are listed up front from the job rules (every window
//               times every kernel, in order); the DUT is compared against
//               those lists cycle by cycle, together with fixed latency,
//               done timing and issue throughput.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sd4_mac_sequencer;

    localparam int KADDR_W  = 4;
    localparam int WIN_W    = 16;
    localparam int PIPE_LAT = 4;
    localparam int NK_MAX   = 1 << KADDR_W;
    localparam int CW       = 160;

    typedef struct packed {
        logic [71:0] img;
        logic [35:0] wgt;
        logic [4:0]  bias;
    } op_t;

    typedef struct packed {
        logic [KADDR_W-1:0] k;
        logic               lw;
        logic               lj;
    } tag_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [KADDR_W-1:0] cfg_num_k;
    logic [WIN_W-1:0]   cfg_num_win;
    logic               busy;
    logic               done;

    sd4_mac_sequencer_if #(.KADDR_W(KADDR_W)) bus ();

    sd4_mac_sequencer #(
        .KADDR_W (KADDR_W),
        .WIN_W   (WIN_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_num_k  (cfg_num_k),
        .cfg_num_win(cfg_num_win),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous weight buffer: data one cycle after the read strobe
    logic [35:0] mem_w [NK_MAX];
    logic [4:0]  mem_b [NK_MAX];
    always @(posedge clk) begin
        if (bus.wgt_rd_en) begin
            bus.wgt_data  <= mem_w[bus.wgt_addr];
            bus.bias_data <= mem_b[bus.wgt_addr];
        end
    end

    logic [128:0] w_outs;
    assign w_outs = {busy, done, bus.img_ready, bus.wgt_rd_en, bus.wgt_addr,
                     bus.image_out, bus.weight_out, bus.exp_bias_out, bus.mac_valid_in,
                     bus.res_valid, bus.res_kidx, bus.res_last_win, bus.res_last_job};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    op_t                op_q [$];
    tag_t               tag_q [$];
    logic [KADDR_W-1:0] addr_q [$];
    int                 mac_cyc_q [$];
    logic [71:0]        windows [$];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // vmode: 0 window always offered, 1 offered every other cycle, 2 random
    task automatic run_job(input int nk, input int nw, input int vmode, input bit noise, input bit zero_w);
        int          idx       = 0;
        int          n_mac     = 0;
        int          n_res     = 0;
        int          first_mac = -1;
        int          last_mac  = 0;
        int          last_res  = -100;
        int          total;
        int          exp_span;
        int          mc;
        bit          seen_done = 1'b0;
        logic        v;
        logic [95:0] r96;
        op_t         eo;
        tag_t        et;
        logic [KADDR_W-1:0] ea;

        total = (nk + 1) * (nw + 1);
        windows.delete(); op_q.delete(); tag_q.delete(); addr_q.delete(); mac_cyc_q.delete();
        for (int w = 0; w <= nw; w++) begin
            r96 = {$urandom, $urandom, $urandom};
            windows.push_back(r96[71:0]);
        end
        for (int k = 0; k < NK_MAX; k++) begin
            r96 = {$urandom, $urandom, $urandom};
            mem_w[k] = zero_w ? 36'd0 : r96[35:0];
            mem_b[k] = 5'($urandom);
        end
        for (int w = 0; w <= nw; w++) begin
            for (int k = 0; k <= nk; k++) begin
                op_q.push_back('{img: windows[w], wgt: mem_w[k], bias: mem_b[k]});
                tag_q.push_back('{k: KADDR_W'(k), lw: (k == nk), lj: (k == nk) && (w == nw)});
                addr_q.push_back(KADDR_W'(k));
            end
        end

        @(negedge clk);
        bus.img_valid = 1'b0;
        #1;
        check("idle_busy", CW'(busy), CW'(0));
        start = 1'b1;
        cfg_num_k = KADDR_W'(nk);
        cfg_num_win = WIN_W'(nw);
        @(negedge clk);
        cfg_num_k = KADDR_W'($urandom);
        cfg_num_win = WIN_W'($urandom);

        for (int t = 0; t < 4000 && !seen_done; t++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (idx > nw) v = 1'b0;
            bus.img_valid = v;
            r96 = {$urandom, $urandom, $urandom};
            if (v) bus.img_data = windows[idx];
            else   bus.img_data = r96[71:0];
            if (noise && (done || (busy && $urandom_range(0, 3) == 0))) begin
                start = 1'b1;
                cfg_num_k = KADDR_W'($urandom);
                cfg_num_win = WIN_W'($urandom);
            end else begin
                start = 1'b0;
            end
            #1;
            check("busy_in_job", CW'(busy), CW'(1));
            if (bus.img_valid && bus.img_ready) idx++;
            if (bus.wgt_rd_en) begin
                check("rd_underflow", CW'(addr_q.size() != 0), CW'(1));
                if (addr_q.size() != 0) begin
                    ea = addr_q.pop_front();
                    check("wgt_addr", CW'(bus.wgt_addr), CW'(ea));
                end
            end
            if (bus.mac_valid_in) begin
                check("op_underflow", CW'(op_q.size() != 0), CW'(1));
                if (op_q.size() != 0) begin
                    eo = op_q.pop_front();
                    check("operands", CW'({bus.image_out, bus.weight_out, bus.exp_bias_out}), CW'(eo));
                end
                mac_cyc_q.push_back(cyc);
                if (first_mac < 0) first_mac = cyc;
                last_mac = cyc;
                n_mac++;
            end else begin
                check("idle_operands", CW'({bus.image_out, bus.weight_out, bus.exp_bias_out}), CW'(0));
            end
            if (bus.res_valid) begin
                check("res_underflow", CW'(tag_q.size() != 0 && mac_cyc_q.size() != 0), CW'(1));
                if (tag_q.size() != 0 && mac_cyc_q.size() != 0) begin
                    et = tag_q.pop_front();
                    mc = mac_cyc_q.pop_front();
                    check("res_tag", CW'({bus.res_kidx, bus.res_last_win, bus.res_last_job}), CW'(et));
                    check("res_latency", CW'(cyc - mc), CW'(PIPE_LAT));
                end
                last_res = cyc;
                n_res++;
            end
            if (done) begin
                check("done_after_last_res", CW'(cyc - last_res), CW'(1));
                check("res_count", CW'(n_res), CW'(total));
                seen_done = 1'b1;
            end
            @(negedge clk);
        end
        check("done_seen", CW'(seen_done), CW'(1));

        start = 1'b0;
        bus.img_valid = 1'b0;
        #1;
        check("done_one_cycle_busy_low", CW'({done, busy}), CW'(0));
        check("mac_count", CW'(n_mac), CW'(total));
        if (vmode == 0) begin
`ifdef SD4_SEQ_PREFETCH_EN
            exp_span = total;
`else
            exp_span = total + nw;
`endif
            check("issue_span", CW'(last_mac - first_mac + 1), CW'(exp_span));
        end
        @(negedge clk);
        #1;
        check("stays_idle", CW'({busy, bus.img_ready, bus.mac_valid_in}), CW'(0));
    endtask

    initial begin
        int          cnt;
        logic [95:0] r96;

        rst = 1'b0;
        start = 1'b0;
        cfg_num_k = '0;
        cfg_num_win = '0;
        bus.img_valid = 1'b0;
        bus.img_data = '0;
        for (int k = 0; k < NK_MAX; k++) begin
            mem_w[k] = 36'd0;
            mem_b[k] = 5'd0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", CW'(w_outs), CW'(0));
        @(negedge clk);
        rst = 1'b1;

        // three kernels, single window, window always offered
        run_job(2, 0, 0, 1'b0, 1'b0);

        // asynchronous reset while issuing kernel 2
        @(negedge clk);
        start = 1'b1;
        cfg_num_k = KADDR_W'(5);
        cfg_num_win = WIN_W'(2);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int t = 0; t < 50 && cnt < 3; t++) begin
            bus.img_valid = 1'b1;
            r96 = {$urandom, $urandom, $urandom};
            bus.img_data = r96[71:0];
            #1;
            if (bus.mac_valid_in) cnt++;
            if (cnt < 3) @(negedge clk);
        end
        check("t1_reached_k2", CW'(cnt), CW'(3));
        rst = 1'b0;
        #1;
        check("t1_outputs_in_reset", CW'(w_outs), CW'(0));
        @(negedge clk);
        #1;
        check("t1_outputs_held", CW'(w_outs), CW'(0));
        @(negedge clk);
        rst = 1'b1;
        bus.img_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            check("t1_quiet_after_reset", CW'({bus.res_valid, done, busy}), CW'(0));
        end

        // single-kernel windows with the window offered every other cycle
        run_job(0, 3, 1, 1'b0, 1'b0);
        // stray starts during the job and in the done cycle, cfg changes
        run_job(3, 2, 2, 1'b1, 1'b0);
        // full kernel range, two windows, throughput
        run_job(15, 1, 0, 1'b0, 1'b0);
        // zero-weight kernels
        run_job(4, 2, 2, 1'b0, 1'b1);
        // back-to-back windows with stray starts
        run_job(1, 4, 0, 1'b1, 1'b0);
        // random jobs
        for (int j = 0; j < 4; j++) begin
            run_job(int'($urandom_range(0, NK_MAX - 1)), int'($urandom_range(0, 3)), 2,
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
